// File: rtl/fc_frame_sequencer_pkg.sv
// Shared FC definitions: read-side FSM encoding and class-index width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fc_frame_sequencer_pkg;

  // Width of the class index reported by the FC core.
  localparam int CLASS_WIDTH = 4;

  // Read-side sequencing of one buffered frame through the FC core.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for the read bank to fill
    ST_FCRST = 2'd1,  // one-cycle reset pulse to the FC core
    ST_RUN   = 2'd2,  // FC core enabled, reading the active bank
    ST_DONE  = 2'd3   // result strobe, bank released
  } fc_state_t;

endpackage

// File: rtl/fc_frame_bank.sv
// Single frame bank: word storage, full flag, stored word count, zero-padded read.
// Latency: write takes effect next cycle; read word is combinational from rd_addr.
// Backpressure: none here; the owner must not write while full is set.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data word write into storage
//   close_en/close_count  mark bank full and record how many words are valid
//   free_en               release the bank (full and count cleared)
//   full                  bank holds a complete frame
//   rd_addr/rd_word       read port; addresses at or beyond count read as 0
module fc_frame_bank
  import fc_frame_sequencer_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  close_en,
  input  logic [CNT_WIDTH-1:0]  close_count,
  input  logic                  free_en,
  output logic                  full,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_word
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_WIDTH-1:0]  count;

  // Storage is not reset: a zero count masks any stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full  <= 1'b0;
      count <= '0;
    end else if (close_en) begin
      full  <= 1'b1;
      count <= close_count;
    end else if (free_en) begin
      full  <= 1'b0;
      count <= '0;
    end
  end

  // Short frames are padded with zeros so the FC core always sees a full layer.
  assign rd_word = (32'(rd_addr) < 32'(count)) ? mem[rd_addr] : '0;

endmodule

// File: rtl/fc_frame_sequencer.sv
// Ping-pong frame buffer feeding an FC core: fills one bank while the FC runs on the other.
// Latency: rd_data one cycle after rd_addr; FC starts 2 cycles after a bank closes (IDLE, FCRST).
// Backpressure: in_ready drops while the fill bank is still full; freed bank is writable the cycle after DONE.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   in_valid/in_data/in_last    feature word stream from the flatten stage
//   in_ready                    word accepted this cycle when in_valid is also high
//   fc_reset/fc_enable          control of the downstream FC core
//   fc_finished/fc_result       FC completion and class index (sampled only in RUN)
//   rd_addr/rd_data             FC read port into the active bank, registered
//   class_out/class_valid       captured class plus one-cycle strobe
//   frame_err                   sticky: a full-length frame arrived without in_last
module fc_frame_sequencer
  import fc_frame_sequencer_pkg::*;
#(
  parameter  int firstLayerNodes = 3,
  parameter  int DATA_WIDTH      = 16,
  localparam int ADDR_WIDTH      = (firstLayerNodes > 1) ? $clog2(firstLayerNodes) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   fc_reset,
  output logic                   fc_enable,
  input  logic                   fc_finished,
  input  logic [CLASS_WIDTH-1:0] fc_result,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [CLASS_WIDTH-1:0] class_out,
  output logic                   class_valid,
  output logic                   frame_err
);

  localparam int CNT_WIDTH = $clog2(firstLayerNodes + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(firstLayerNodes - 1);

  fc_state_t             state, state_nxt;
  logic                  fill_bank;
  logic                  rd_bank;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  accept;
  logic                  close_frame;
  logic                  free_bank;
  logic                  full0, full1;
  logic [DATA_WIDTH-1:0] word0, word1;
  logic [CNT_WIDTH-1:0]  close_count;

  // ---------------------------------------------------------------- fill side
  // Ready depends only on the registered full flag of the fill bank, so a bank
  // released in DONE cannot be written until the next cycle.
  assign in_ready    = ~reset & ~(fill_bank ? full1 : full0);
  assign accept      = in_valid & in_ready;
  assign close_frame = accept & ((wr_ptr == LAST_PTR) | in_last);
  assign close_count = CNT_WIDTH'(wr_ptr) + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      fill_bank <= 1'b0;
      frame_err <= 1'b0;
    end else if (accept) begin
      if (close_frame) begin
        wr_ptr    <= '0;
        fill_bank <= ~fill_bank;
      end else begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      // Frame hit its length limit without a marker: close it anyway, flag it.
      if ((wr_ptr == LAST_PTR) && !in_last) begin
        frame_err <= 1'b1;
      end
    end
  end

  fc_frame_bank #(
    .DEPTH      (firstLayerNodes),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_bank0 (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (accept & ~fill_bank),
    .wr_addr     (wr_ptr),
    .wr_data     (in_data),
    .close_en    (close_frame & ~fill_bank),
    .close_count (close_count),
    .free_en     (free_bank & ~rd_bank),
    .full        (full0),
    .rd_addr     (rd_addr),
    .rd_word     (word0)
  );

  fc_frame_bank #(
    .DEPTH      (firstLayerNodes),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_bank1 (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (accept & fill_bank),
    .wr_addr     (wr_ptr),
    .wr_data     (in_data),
    .close_en    (close_frame & fill_bank),
    .close_count (close_count),
    .free_en     (free_bank & rd_bank),
    .full        (full1),
    .rd_addr     (rd_addr),
    .rd_word     (word1)
  );

  // ---------------------------------------------------------------- read side
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (rd_bank ? full1 : full0) state_nxt = ST_FCRST;
      ST_FCRST: state_nxt = ST_RUN;
      ST_RUN:   if (fc_finished) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The FC core is held in reset for as long as this block is.
  always_comb begin
    fc_reset    = reset;
    fc_enable   = 1'b0;
    class_valid = 1'b0;
    free_bank   = 1'b0;
    if (!reset) begin
      case (state)
        ST_FCRST: fc_reset = 1'b1;
        ST_RUN:   fc_enable = 1'b1;
        ST_DONE: begin
          class_valid = 1'b1;
          free_bank   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank   <= 1'b0;
      class_out <= '0;
      rd_data   <= '0;
    end else begin
      rd_data <= rd_bank ? word1 : word0;
      if ((state == ST_RUN) && fc_finished) begin
        class_out <= fc_result;
      end
      if (state == ST_DONE) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_fc_frame_sequencer.sv
module tb_fc_frame_sequencer;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam bit PAD_PROBE = (N < (1 << AW));

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          fc_reset;
  logic          fc_enable;
  logic          fc_finished;
  logic [3:0]    fc_result;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [3:0]    class_out;
  logic          class_valid;
  logic          frame_err;

  always #5 clk = ~clk;

  fc_frame_sequencer #(.firstLayerNodes(N), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .fc_reset    (fc_reset),
    .fc_enable   (fc_enable),
    .fc_finished (fc_finished),
    .fc_result   (fc_result),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .class_out   (class_out),
    .class_valid (class_valid),
    .frame_err   (frame_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: every accepted frame is a layer of N words, zero padded,
  // whose class is the low nibble of the word sum.
  logic [DW-1:0] exp_words[$];
  logic [3:0]    exp_class[$];
  bit            model_err  = 1'b0;
  bit            stall_long = 1'b0;
  bit            use_gaps   = 1'b0;
  logic [DW-1:0] fr [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ------------------------------------------------------------- FC core model
  initial begin : fc_model
    int unsigned acc;
    int          dly;
    bit          aborted;
    logic [DW-1:0] want;
    fc_finished = 1'b0;
    fc_result   = '0;
    rd_addr     = '0;
    forever begin
      @(posedge clk); #1;
      fc_finished = 1'b0;
      if (!reset && fc_enable) begin
        aborted = 1'b0;
        acc     = 0;
        if (exp_words.size() < N) note_fail("run_without_frame");
        for (int a = 0; a <= N; a++) begin
          if (a == N && !PAD_PROBE) break;
          rd_addr = AW'(a);
          @(posedge clk); #1;
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          want = (a < N && a < exp_words.size()) ? exp_words[a] : DW'(0);
          chk(a < N ? "rd_data" : "rd_data_pad", rd_data, want);
          if (a < N) acc += rd_data;
        end
        if (!aborted) begin
          for (int i = 0; i < N; i++) if (exp_words.size() > 0) void'(exp_words.pop_front());
          dly = stall_long ? 30 : $urandom_range(0, 6);
          for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            if (reset) begin
              aborted = 1'b1;
              break;
            end
          end
          if (!aborted) begin
            fc_finished = 1'b1;
            fc_result   = acc[3:0];
          end
        end
      end else if (!reset && $urandom_range(0, 7) == 0) begin
        // Spurious completion while not running must be ignored.
        fc_finished = 1'b1;
        fc_result   = 4'($urandom);
      end
    end
  end

  // ------------------------------------------------------------- output monitor
  logic prev_en  = 1'b0;
  logic prev_rst = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (class_valid) begin
        chk("enable_low_in_done", fc_enable, 0);
        if (exp_class.size() == 0) note_fail("class_unexpected");
        else chk("class_out", class_out, exp_class.pop_front());
      end
      if (fc_enable && !prev_en) chk("fcrst_before_run", prev_rst, 1);
      if (fc_enable && fc_reset) note_fail("reset_and_enable");
    end
    prev_en  = fc_enable;
    prev_rst = fc_reset;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- stimulus
  task automatic send_word(input logic [DW-1:0] d, input bit last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) note_fail("in_ready_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit with_last);
    int unsigned s = 0;
    for (int i = 0; i < N; i++) begin
      exp_words.push_back((i < len) ? fr[i] : DW'(0));
      if (i < len) s += fr[i];
    end
    exp_class.push_back(s[3:0]);
    if (!with_last) model_err = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (use_gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_word(fr[i], with_last && (i == len - 1));
    end
    chk("frame_err", frame_err, model_err);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_class.size() != 0 || fc_enable || fc_reset) && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 5000) note_fail("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int  g;
    bit  seen;
    int  len;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fc_reset", fc_reset, 1);
    chk("rst_fc_enable", fc_enable, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_class_out", class_out, 0);
    chk("rst_class_valid", class_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_fc_reset", fc_reset, 0);
    @(posedge clk); #1;

    // Directed frames: full, short, missing marker, then a normal one.
    fr[0] = 16'd10; fr[1] = 16'd20; fr[2] = 16'd30; send_frame(3, 1'b1);
    fr[0] = 16'd5;  fr[1] = 16'd6;                  send_frame(2, 1'b1);
    fr[0] = 16'd1;  fr[1] = 16'd2;  fr[2] = 16'd3;  send_frame(3, 1'b0);
    fr[0] = 16'd7;  fr[1] = 16'd8;  fr[2] = 16'd9;  send_frame(3, 1'b1);
    drain();

    // Both banks filled against a stalled FC core.
    stall_long = 1'b1;
    fr[0] = 16'h111; fr[1] = 16'h222; fr[2] = 16'h333; send_frame(3, 1'b1);
    fr[0] = 16'h444; fr[1] = 16'h555; fr[2] = 16'h666; send_frame(3, 1'b1);
    chk("ready_both_full", in_ready, 0);
    stall_long = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (class_valid) begin
        chk("ready_in_done", in_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_done", in_ready, 1);
        seen = 1'b1;
        break;
      end
      chk("ready_stalled", in_ready, 0);
    end
    if (!seen) note_fail("stall_done_timeout");
    drain();

    // Reset while the FC core is running.
    fr[0] = 16'd1; fr[1] = 16'd2; fr[2] = 16'd3; send_frame(3, 1'b1);
    g = 0;
    while (!fc_enable && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!fc_enable) note_fail("run_start_timeout");
    #1;
    reset = 1'b1;
    exp_words.delete();
    exp_class.delete();
    model_err = 1'b0;
    #1;
    chk("midrun_fc_reset", fc_reset, 1);
    chk("midrun_fc_enable", fc_enable, 0);
    chk("midrun_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("midrun_rd_data", rd_data, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_in_ready", in_ready, 1);
    chk("after_rst_frame_err", frame_err, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("after_rst_idle_enable", fc_enable, 0);
      chk("after_rst_no_class", class_valid, 0);
    end

    // Randomized traffic with random gaps and random FC run lengths.
    use_gaps = 1'b1;
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(1, N);
      for (int i = 0; i < N; i++) fr[i] = DW'($urandom);
      send_frame(len, (len < N) ? 1'b1 : ($urandom_range(0, 3) != 0));
    end
    drain();
    chk("final_frame_err", frame_err, model_err);
    chk("final_words_left", exp_words.size(), 0);
    chk("final_in_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fc_frame_sequencer.md
FC_FRAME_SEQUENCER -- requirements
Module: fc_frame_sequencer

Interface
REQ-001 SHALL have parameter firstLayerNodes, default 3: number of flattened feature words per frame (FC input layer size).
REQ-002 SHALL have parameter DATA_WIDTH, default 16: feature word width in bits.
REQ-003 SHALL have derived parameter ADDR_WIDTH = max(1, clog2(firstLayerNodes)).
REQ-004 Clock and reset: clk  input  1  single clock; reset  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream feature word valid.
REQ-006 in_data  input  DATA_WIDTH  feature word from pooling/flatten stage.
REQ-007 in_last  input  1  marks last word of a frame.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 fc_reset  output  1  reset to downstream FC core.
REQ-010 fc_enable  output  1  run enable to FC core.
REQ-011 fc_finished  input  1  FC core done.
REQ-012 fc_result  input  4  FC class index, valid while fc_finished=1.
REQ-013 rd_addr  input  ADDR_WIDTH  FC read address into active bank.
REQ-014 rd_data  output  DATA_WIDTH  registered read data.
REQ-015 class_out  output  4 and class_valid  output  1: captured result plus 1-cycle strobe.
REQ-016 frame_err  output  1  sticky frame-length error.

Function
REQ-017 SHALL hold two banks (ping-pong) of firstLayerNodes words, each with a full flag and a word count.
REQ-018 A word SHALL be accepted on in_valid && in_ready; it is written to fill bank at wr_ptr, and wr_ptr increments.
REQ-019 in_ready SHALL be 1 iff the current fill bank is not full, computed from registered flags only.
REQ-020 A fill bank SHALL close (full=1, count stored, wr_ptr=0, fill bank toggles) on an accepted word when wr_ptr=firstLayerNodes-1 or in_last=1.
REQ-021 Short frame (in_last before the firstLayerNodes-th word): SHALL close early; reads at addr >= count SHALL return 0.
REQ-022 Full-length frame with in_last=0 on the final word: SHALL close anyway and set frame_err; the next words start a new frame.
REQ-023 Read FSM states: IDLE, FCRST, RUN, DONE.
REQ-024 IDLE -> FCRST when read bank is full; FCRST lasts exactly 1 cycle with fc_reset=1, fc_enable=0.
REQ-025 RUN: fc_enable=1 until fc_finished=1 is sampled; then -> DONE, capturing fc_result into class_out.
REQ-026 DONE (1 cycle): class_valid=1, fc_enable=0, read bank full flag cleared, read bank toggled; -> IDLE.
REQ-027 rd_data SHALL equal the read-bank word at rd_addr registered one cycle after rd_addr, or 0 for addr >= count.
REQ-028 Bank freed in DONE SHALL become writable on the following cycle, never in the same cycle.
REQ-029 Concurrent fill of one bank and FC run on the other SHALL proceed without stalling either side.
REQ-030 fc_finished outside RUN SHALL be ignored.

Reset
REQ-031 On reset: both full flags 0, counts 0, wr_ptr 0, fill bank 0, read bank 0, FSM IDLE.
REQ-032 Output values during/after reset: in_ready 0 during reset then 1; fc_reset = 1 while reset is high; fc_enable 0; rd_data 0; class_out 0; class_valid 0; frame_err 0.
REQ-033 Reset mid-RUN or mid-fill SHALL discard all buffered data; no class_valid is emitted.

Structure
REQ-034 FSM state encoding and the 4-bit class width constant SHALL live in the shared FC package.
REQ-035 One sub-module, fc_frame_bank (single bank storage + count + zero-pad read), SHALL be instantiated twice.

Verification
REQ-036 firstLayerNodes=3, stream 10,20,30 (last on 30) -> FCRST 1 cycle, then fc_enable=1; rd_addr 0..2 -> rd_data 10,20,30 one cycle later.
REQ-037 Model FC with fc_finished after 5 RUN cycles and fc_result=4'd7 -> class_out=7, class_valid 1 cycle, fc_enable falls in the same cycle.
REQ-038 Stream 6 words back-to-back with a stalled FC -> both banks full, in_ready=0 on the 7th word until DONE+1.
REQ-039 Frame 5,6 with in_last on 6 -> rd_addr 2 returns 0; frame_err stays 0.
REQ-040 3 words without in_last -> frame_err=1 sticky; second frame processed normally.
REQ-041 Assert reset during RUN -> fc_reset=1, fc_enable=0, in_ready=0 next cycle, no class_valid, both banks empty afterwards.
